// File: rtl/uart_encoder.sv
// UART transmitter: byte FIFO feeding an 8N1/8N2 serialiser, LSB first.
// tx is registered and only moves on state or bit boundaries.
module uart_encoder #(
    parameter int CLK_PER_BIT = 10,
    parameter int FIFO_DEPTH  = 4,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       hold,
    output logic       tx,
    output logic       busy,
    output logic [4:0] fifo_level
);

    localparam int         PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [8:0] BIT_LOAD  = 9'(CLK_PER_BIT - 1);
    localparam logic [8:0] STOP_LOAD = 9'(STOP_BITS * CLK_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [4:0]       level;
    logic [1:0]       state;
    logic [8:0]       timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tx_q;
    logic             push;
    logic             pop;
    logic             can_start;

    assign in_ready   = (level != 5'(FIFO_DEPTH));
    assign push       = in_valid & in_ready;
    assign can_start  = (level != '0) & ~hold;
    assign tx         = tx_q;
    assign busy       = (state != IDLE) | (level != '0);
    assign fifo_level = level;

    // hold is only looked at when a new frame could begin.
    // NOTE: always_comb assigns a default first so no path leaves pop unassigned (no latch).
    always_comb begin
        pop = 1'b0;
        if (state == IDLE || (state == STOP && timer == '0))
            pop = can_start;
    end

    // NOTE: the data array is left out of reset; level/pointers define validity, and an
    // unreset array maps onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 5'd1;
            else if (pop && !push)
                level <= level - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        timer <= BIT_LOAD;
                        tx_q  <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (timer == '0) begin
                        timer   <= BIT_LOAD;
                        bit_idx <= '0;
                        tx_q    <= shift[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer - 9'd1;
                    end
                end
                DATA: begin
                    if (timer == '0) begin
                        if (bit_idx == 3'd7) begin
                            timer <= STOP_LOAD;
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            timer   <= BIT_LOAD;
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - 9'd1;
                    end
                end
                STOP: begin
                    // Back-to-back frames: next start bit follows the last stop cycle directly.
                    if (timer == '0) begin
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            timer <= BIT_LOAD;
                            tx_q  <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer - 9'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
